// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 800x600@60 timing constants, coordinate and colour types, and a
// helper for clipping window bounds to the visible area.
// Ports: none (package).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

   // Horizontal timing in pixel clocks
   localparam int H_VISIBLE = 800;
   localparam int H_FRONT   = 40;
   localparam int H_SYNC    = 128;
   localparam int H_BACK    = 88;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   // Vertical timing in lines
   localparam int V_VISIBLE = 600;
   localparam int V_FRONT   = 1;
   localparam int V_SYNC    = 4;
   localparam int V_BACK    = 23;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Screen coordinates are 11-bit unsigned throughout
   localparam int COORD_W  = 11;
   localparam int TILE_DIM = 16;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic red;
      logic green;
      logic blue;
   } rgb_t;

   // Where the current pixel falls on the screen
   typedef enum logic [1:0] {
      REGION_BLANK,
      REGION_BORDER,
      REGION_WINDOW
   } region_t;

   // Clamps an elaboration-time coordinate into 0..limit so window bounds
   // never wrap in 11-bit arithmetic; an off-screen window collapses to empty.
   function automatic coord_t clip_coord(input int value, input int limit);
      if (value < 0)
         return '0;
      else if (value > limit)
         return coord_t'(limit);
      else
         return coord_t'(value);
   endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// Free-running 800x600@60 raster counters with combinational decode of the
// visible flag, both sync levels and the once-per-frame commit strobe.
// Ports:
//   CLK_40Mhz  in   pixel clock
//   RSTn       in   asynchronous active-low reset (counters to 0,0)
//   h_count    out  current column 0..1055
//   v_count    out  current line 0..627
//   visible    out  counters inside the 800x600 active area
//   hsync      out  horizontal sync level (active-high)
//   vsync      out  vertical sync level (active-high)
//   commit     out  high for the single cycle at H=0, V=600
// ---------------------------------------------------------------------------
module vga_sync_gen
   import vga_timing_pkg::*;
(
   input  logic   CLK_40Mhz,
   input  logic   RSTn,
   output coord_t h_count,
   output coord_t v_count,
   output logic   visible,
   output logic   hsync,
   output logic   vsync,
   output logic   commit
);

   localparam coord_t H_LAST      = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST      = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS       = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS       = coord_t'(V_VISIBLE);
   localparam coord_t HSYNC_START = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HSYNC_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t VSYNC_START = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VSYNC_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

   // The line counter only moves when the column counter wraps, so a frame
   // is exactly H_TOTAL * V_TOTAL clocks.
   always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
      if (!RSTn) begin
         h_count <= '0;
         v_count <= '0;
      end else if (h_count == H_LAST) begin
         h_count <= '0;
         v_count <= (v_count == V_LAST) ? '0 : v_count + coord_t'(1);
      end else begin
         h_count <= h_count + coord_t'(1);
      end
   end

   // Decode is left combinational; the renderer registers it alongside the
   // colour so all outputs share one cycle of latency.
   always_comb begin
      visible = (h_count < H_VIS) && (v_count < V_VIS);
      hsync   = (h_count >= HSYNC_START) && (h_count < HSYNC_END);
      vsync   = (v_count >= VSYNC_START) && (v_count < VSYNC_END);
      commit  = (h_count == '0) && (v_count == V_VIS);
   end

endmodule

// File: rtl/vga_tile_renderer.sv
// ---------------------------------------------------------------------------
// vga_tile_renderer
// Displays a double-buffered 16x16 monochrome bitmap, scaled by
// 2^SCALE_LOG2, inside an 800x600@60 raster. Rows are written into a shadow
// buffer at any time; the shadow is copied to the displayed buffer once per
// frame at the start of vertical blanking so the image never tears.
// Ports:
//   CLK_40Mhz        in   pixel clock
//   RSTn             in   asynchronous active-low reset
//   Write_En_Sig     in   row write strobe, one row per high cycle
//   Write_Addr_Sig   in   bitmap row 0..15
//   Write_Data       in   row bits, bit 15 is the leftmost pixel
//   HSYNC_Sig        out  horizontal sync, active-high
//   VSYNC_Sig        out  vertical sync, active-high
//   Red_Sig          out  pixel red
//   Green_Sig        out  pixel green
//   Blue_Sig         out  pixel blue
//   Frame_Start_Sig  out  one-cycle pulse marking the buffer commit
// ---------------------------------------------------------------------------
module vga_tile_renderer
   import vga_timing_pkg::*;
#(
   parameter int         ORG_X      = 336,
   parameter int         ORG_Y      = 236,
   parameter int         SCALE_LOG2 = 3,
   parameter logic [2:0] FG_COLOR   = 3'b010,
   parameter logic [2:0] BG_COLOR   = 3'b000
)(
   input  logic        CLK_40Mhz,
   input  logic        RSTn,
   input  logic        Write_En_Sig,
   input  logic [3:0]  Write_Addr_Sig,
   input  logic [15:0] Write_Data,
   output logic        HSYNC_Sig,
   output logic        VSYNC_Sig,
   output logic        Red_Sig,
   output logic        Green_Sig,
   output logic        Blue_Sig,
   output logic        Frame_Start_Sig
);

   localparam int WIN_SIZE = TILE_DIM << SCALE_LOG2;

   // Window bounds are clipped to the visible area up front, so the run-time
   // comparisons can never wrap regardless of how the parameters are set.
   localparam coord_t X_LO = clip_coord(ORG_X, H_VISIBLE);
   localparam coord_t X_HI = clip_coord(ORG_X + WIN_SIZE, H_VISIBLE);
   localparam coord_t Y_LO = clip_coord(ORG_Y, V_VISIBLE);
   localparam coord_t Y_HI = clip_coord(ORG_Y + WIN_SIZE, V_VISIBLE);

   coord_t  h_count;
   coord_t  v_count;
   logic    visible;
   logic    hsync;
   logic    vsync;
   logic    commit;

   logic [TILE_DIM-1:0] shadow_buf  [TILE_DIM];
   logic [TILE_DIM-1:0] shadow_next [TILE_DIM];
   logic [TILE_DIM-1:0] active_buf  [TILE_DIM];

   logic    in_window;
   coord_t  dx;
   coord_t  dy;
   logic [3:0] col;
   logic [3:0] row;
   logic    tile_bit;
   region_t region;
   rgb_t    colour_next;
   rgb_t    colour_q;

   vga_sync_gen u_sync (
      .CLK_40Mhz (CLK_40Mhz),
      .RSTn      (RSTn),
      .h_count   (h_count),
      .v_count   (v_count),
      .visible   (visible),
      .hsync     (hsync),
      .vsync     (vsync),
      .commit    (commit)
   );

   // Shadow contents as they will be after this cycle's write. The commit
   // copies this rather than shadow_buf so a write landing on the commit
   // cycle still makes it into the new frame.
   always_comb begin
      shadow_next = shadow_buf;
      if (Write_En_Sig)
         shadow_next[Write_Addr_Sig] = Write_Data;
   end

   always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < TILE_DIM; i++)
            shadow_buf[i] <= '0;
      end else begin
         shadow_buf <= shadow_next;
      end
   end

   // The displayed buffer only changes at the commit point, which lies in
   // vertical blanking, so no visible line ever mixes two images.
   always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < TILE_DIM; i++)
            active_buf[i] <= '0;
      end else if (commit) begin
         active_buf <= shadow_next;
      end
   end

   // Map the raster position onto a bitmap cell. The offsets are only
   // meaningful inside the window, where they are below WIN_SIZE and the
   // shifted value fits in four bits. Bit 15 is leftmost, hence ~col.
   always_comb begin
      in_window = visible &&
                  (h_count >= X_LO) && (h_count < X_HI) &&
                  (v_count >= Y_LO) && (v_count < Y_HI);
      dx        = h_count - X_LO;
      dy        = v_count - Y_LO;
      col       = 4'(dx >> SCALE_LOG2);
      row       = 4'(dy >> SCALE_LOG2);
      tile_bit  = active_buf[row][~col];
   end

   always_comb begin
      region = REGION_BLANK;
      if (visible)
         region = in_window ? REGION_WINDOW : REGION_BORDER;
   end

   always_comb begin
      colour_next = rgb_t'(3'b000);
      case (region)
         REGION_WINDOW: colour_next = tile_bit ? rgb_t'(FG_COLOR) : rgb_t'(BG_COLOR);
         REGION_BORDER: colour_next = rgb_t'(BG_COLOR);
         default:       colour_next = rgb_t'(3'b000);
      endcase
   end

   // Sync, colour and the commit marker are registered together so they
   // all describe the same raster position one clock after the counters.
   always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
      if (!RSTn) begin
         HSYNC_Sig       <= 1'b0;
         VSYNC_Sig       <= 1'b0;
         Frame_Start_Sig <= 1'b0;
         colour_q        <= rgb_t'(3'b000);
      end else begin
         HSYNC_Sig       <= hsync;
         VSYNC_Sig       <= vsync;
         Frame_Start_Sig <= commit;
         colour_q        <= colour_next;
      end
   end

   assign Red_Sig   = colour_q.red;
   assign Green_Sig = colour_q.green;
   assign Blue_Sig  = colour_q.blue;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// ---------------------------------------------------------------------------
// tb_vga_tile_renderer
// Directed bench for vga_tile_renderer with default parameters (window at
// 336,236, 8x scale, green on black). A raster-position model tracks which
// counter values each output cycle describes; expected values are constants
// worked out by hand for each probe point and per-frame tally.
// ---------------------------------------------------------------------------
module tb_vga_tile_renderer;

   localparam int FG = 2;
   localparam int HS = 16;
   localparam int VS = 8;

   logic        CLK_40Mhz = 1'b0;
   logic        RSTn = 1'b0;
   logic        Write_En_Sig = 1'b0;
   logic [3:0]  Write_Addr_Sig = '0;
   logic [15:0] Write_Data = '0;
   logic        HSYNC_Sig;
   logic        VSYNC_Sig;
   logic        Red_Sig;
   logic        Green_Sig;
   logic        Blue_Sig;
   logic        Frame_Start_Sig;

   vga_tile_renderer dut (
      .CLK_40Mhz       (CLK_40Mhz),
      .RSTn            (RSTn),
      .Write_En_Sig    (Write_En_Sig),
      .Write_Addr_Sig  (Write_Addr_Sig),
      .Write_Data      (Write_Data),
      .HSYNC_Sig       (HSYNC_Sig),
      .VSYNC_Sig       (VSYNC_Sig),
      .Red_Sig         (Red_Sig),
      .Green_Sig       (Green_Sig),
      .Blue_Sig        (Blue_Sig),
      .Frame_Start_Sig (Frame_Start_Sig)
   );

   always #5 CLK_40Mhz = ~CLK_40Mhz;

   int total_cnt = 0;
   int bad_cnt   = 0;

   // Model of the DUT counters and of the position the outputs describe
   int cnt_h = 0, cnt_v = 0, out_h = 0, out_v = 0, frame_no = 0;
   int abs_cyc = 0, cyc_rel = 0, prev_fs_cyc = 0;

   // Per-frame tallies
   int hs_line0, hs_first, hs_last, vs_cnt, vs_first, vs_last;
   int green_cnt, rb_cnt, blank_nz, border_g;
   int fs_cnt, fs_h, fs_v, fs_rel, fs_period;

   typedef struct {
      int    frame;
      int    h;
      int    v;
      int    expv;
      string tag;
   } probe_t;

   probe_t probes[$];
   int     probe_map[int];

   task automatic checkOutput(input string tag, input int actual, input int expected);
      total_cnt++;
      if (actual != expected) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic clearStats();
      hs_line0 = 0; hs_first = -1; hs_last = -1;
      vs_cnt = 0; vs_first = -1; vs_last = -1;
      green_cnt = 0; rb_cnt = 0; blank_nz = 0; border_g = 0;
      fs_cnt = 0; fs_h = -1; fs_v = -1;
   endtask

   // One clock: outputs sampled 1 time unit after the edge describe the
   // counter values that were present at that edge.
   task automatic stepCycle();
      logic [4:0] sample;
      int key;
      @(posedge CLK_40Mhz);
      #1;
      out_h = cnt_h;
      out_v = cnt_v;
      if (cnt_h == 1055) begin
         cnt_h = 0;
         cnt_v = (cnt_v == 627) ? 0 : cnt_v + 1;
      end else begin
         cnt_h++;
      end
      abs_cyc++;
      cyc_rel++;
      if (out_h == 0 && out_v == 0) begin
         frame_no++;
         clearStats();
      end
      sample = {HSYNC_Sig, VSYNC_Sig, Red_Sig, Green_Sig, Blue_Sig};
      if (out_v == 0 && HSYNC_Sig) begin
         hs_line0++;
         if (hs_first < 0) hs_first = out_h;
         hs_last = out_h;
      end
      if (VSYNC_Sig) begin
         vs_cnt++;
         if (vs_first < 0) vs_first = out_v;
         vs_last = out_v;
      end
      if (Green_Sig) green_cnt++;
      if (Red_Sig || Blue_Sig) rb_cnt++;
      if ((out_h >= 800 || out_v >= 600) && sample[2:0] != 3'b000) blank_nz++;
      if (Green_Sig && (out_h == 335 || out_h == 464 || out_v == 235 || out_v == 364))
         border_g++;
      if (Frame_Start_Sig) begin
         fs_cnt++;
         fs_h = out_h;
         fs_v = out_v;
         fs_rel = cyc_rel;
         fs_period = abs_cyc - prev_fs_cyc;
         prev_fs_cyc = abs_cyc;
      end
      key = frame_no * 700000 + out_v * 1056 + out_h;
      if (probe_map.exists(key))
         checkOutput(probes[probe_map[key]].tag, int'(sample), probes[probe_map[key]].expv);
   endtask

   task automatic runUntil(input int h, input int v);
      do stepCycle(); while (!(cnt_h == h && cnt_v == v));
   endtask

   task automatic applyStimulus(input logic [3:0] addr, input logic [15:0] data);
      Write_En_Sig   = 1'b1;
      Write_Addr_Sig = addr;
      Write_Data     = data;
      stepCycle();
      Write_En_Sig   = 1'b0;
   endtask

   task automatic addProbe(input int f, input int h, input int v, input int e, input string t);
      probes.push_back('{f, h, v, e, t});
      probe_map[f * 700000 + v * 1056 + h] = probes.size() - 1;
   endtask

   initial begin
      clearStats();
      // Frame 1: first frame after reset, pending writes must stay hidden
      addProbe(1, 0, 0, 0, "f1_first_pixel");
      addProbe(1, 336, 236, 0, "f1_row0_hidden");
      addProbe(1, 336, 252, 0, "f1_row2_hidden");
      // Frame 2: row0=8001, row2=FF00, row5=FFFF
      addProbe(2, 336, 236, FG, "f2_r0_left_tl");
      addProbe(2, 343, 243, FG, "f2_r0_left_br");
      addProbe(2, 344, 240, 0, "f2_r0_col1");
      addProbe(2, 455, 236, 0, "f2_r0_col14");
      addProbe(2, 456, 236, FG, "f2_r0_right_tl");
      addProbe(2, 463, 243, FG, "f2_r0_right_br");
      addProbe(2, 464, 243, 0, "f2_r0_past_win");
      addProbe(2, 335, 236, 0, "f2_r0_before_win");
      addProbe(2, 336, 244, 0, "f2_r1_blank");
      addProbe(2, 336, 235, 0, "f2_above_win");
      addProbe(2, 336, 252, FG, "f2_r2_col0");
      addProbe(2, 399, 259, FG, "f2_r2_col7");
      addProbe(2, 400, 252, 0, "f2_r2_col8");
      addProbe(2, 463, 255, 0, "f2_r2_col15");
      addProbe(2, 336, 276, FG, "f2_r5_col0");
      addProbe(2, 400, 280, FG, "f2_r5_col8");
      addProbe(2, 463, 283, FG, "f2_r5_col15");
      addProbe(2, 464, 280, 0, "f2_r5_past_win");
      addProbe(2, 336, 284, 0, "f2_r6_blank");
      addProbe(2, 839, 0, 0, "f2_pre_hsync");
      addProbe(2, 840, 0, HS, "f2_hsync_start");
      addProbe(2, 967, 0, HS, "f2_hsync_end");
      addProbe(2, 968, 0, 0, "f2_post_hsync");
      addProbe(2, 900, 300, HS, "f2_hblank_line300");
      // Frame 3: all-ones bitmap
      addProbe(3, 336, 236, FG, "f3_top_left");
      addProbe(3, 463, 363, FG, "f3_bottom_right");
      addProbe(3, 336, 300, FG, "f3_mid_left");
      addProbe(3, 335, 300, 0, "f3_left_edge");
      addProbe(3, 464, 300, 0, "f3_right_edge");
      addProbe(3, 400, 235, 0, "f3_top_edge");
      addProbe(3, 400, 364, 0, "f3_bottom_edge");
      addProbe(3, 799, 599, 0, "f3_last_visible");
      addProbe(3, 800, 240, 0, "f3_hblank");
      addProbe(3, 840, 602, HS + VS, "f3_both_sync");
      addProbe(3, 0, 600, 0, "f3_vblank_600");
      addProbe(3, 0, 605, 0, "f3_after_vsync");
      // Frame 10: first frame after the mid-frame reset
      addProbe(10, 0, 0, 0, "f10_first_pixel");
      addProbe(10, 336, 236, 0, "f10_blank_window");
      addProbe(11, 336, 236, 0, "f11_blank_tl");
      addProbe(11, 463, 363, 0, "f11_blank_br");

      repeat (3) @(posedge CLK_40Mhz);
      #1;
      checkOutput("reset_outputs",
                  int'({HSYNC_Sig, VSYNC_Sig, Red_Sig, Green_Sig, Blue_Sig, Frame_Start_Sig}), 0);
      RSTn = 1'b1;

      // Frame 1
      runUntil(500, 100);
      applyStimulus(4'd0, 16'h8001);
      runUntil(0, 120);
      applyStimulus(4'd2, 16'h00FF);
      runUntil(0, 130);
      applyStimulus(4'd2, 16'hFF00);
      runUntil(0, 600);
      applyStimulus(4'd5, 16'hFFFF);
      runUntil(0, 0);
      checkOutput("f1_hsync_width", hs_line0, 128);
      checkOutput("f1_hsync_first", hs_first, 840);
      checkOutput("f1_hsync_last", hs_last, 967);
      checkOutput("f1_vsync_cycles", vs_cnt, 4224);
      checkOutput("f1_vsync_first", vs_first, 601);
      checkOutput("f1_vsync_last", vs_last, 604);
      checkOutput("f1_fs_count", fs_cnt, 1);
      checkOutput("f1_fs_h", fs_h, 0);
      checkOutput("f1_fs_v", fs_v, 600);
      checkOutput("f1_fs_latency", fs_rel, 633601);
      checkOutput("f1_green_pixels", green_cnt, 0);
      checkOutput("f1_blank_colour", blank_nz, 0);

      // Frame 2: load the all-ones image after the window has been drawn
      runUntil(0, 400);
      for (int r = 0; r < 16; r++)
         applyStimulus(4'(r), 16'hFFFF);
      runUntil(0, 0);
      checkOutput("f2_green_pixels", green_cnt, 1664);
      checkOutput("f2_red_blue", rb_cnt, 0);
      checkOutput("f2_fs_count", fs_cnt, 1);
      checkOutput("f2_frame_period", fs_period, 663168);

      // Frame 3
      runUntil(0, 0);
      checkOutput("f3_green_pixels", green_cnt, 16384);
      checkOutput("f3_border_green", border_g, 0);
      checkOutput("f3_blank_colour", blank_nz, 0);
      checkOutput("f3_red_blue", rb_cnt, 0);
      checkOutput("f3_vsync_cycles", vs_cnt, 4224);

      // Frame 4: reset in the middle of the picture
      runUntil(500, 300);
      RSTn = 1'b0;
      #2;
      checkOutput("async_reset_outputs",
                  int'({HSYNC_Sig, VSYNC_Sig, Red_Sig, Green_Sig, Blue_Sig, Frame_Start_Sig}), 0);
      repeat (3) @(posedge CLK_40Mhz);
      #1;
      checkOutput("held_reset_outputs",
                  int'({HSYNC_Sig, VSYNC_Sig, Red_Sig, Green_Sig, Blue_Sig, Frame_Start_Sig}), 0);
      RSTn = 1'b1;
      cnt_h = 0;
      cnt_v = 0;
      frame_no = 9;
      cyc_rel = 0;

      // Frame 10: restart from (0,0), buffers cleared
      runUntil(0, 0);
      checkOutput("f10_fs_count", fs_cnt, 1);
      checkOutput("f10_fs_latency", fs_rel, 633601);
      checkOutput("f10_fs_v", fs_v, 600);
      checkOutput("f10_hsync_width", hs_line0, 128);
      checkOutput("f10_green_pixels", green_cnt, 0);

      // Frame 11: image after the first commit following reset
      runUntil(0, 370);
      checkOutput("f11_green_pixels", green_cnt, 0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/vga_tile_renderer.md
VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

Interface
REQ-001 SHALL have parameter ORG_X, default 336, left pixel column of the bitmap window.
REQ-002 SHALL have parameter ORG_Y, default 236, top line of the bitmap window.
REQ-003 SHALL have parameter SCALE_LOG2, default 3, window pixel = 2^SCALE_LOG2 screen pixels square (default 128x128).
REQ-004 SHALL have parameter FG_COLOR, default 3'b010, {R,G,B} for set bits.
REQ-005 SHALL have parameter BG_COLOR, default 3'b000, {R,G,B} for clear bits and the visible area outside the window.
REQ-006 CLK_40Mhz  input  1  pixel clock, 40 MHz.
REQ-007 RSTn  input  1  asynchronous, active-low reset.
REQ-008 Write_En_Sig  input  1  row-write strobe, one row per high cycle.
REQ-009 Write_Addr_Sig  input  4  bitmap row index 0..15.
REQ-010 Write_Data  input  16  row bits, bit 15 = leftmost pixel.
REQ-011 HSYNC_Sig  output  1  horizontal sync, active-high.
REQ-012 VSYNC_Sig  output  1  vertical sync, active-high.
REQ-013 Red_Sig, Green_Sig, Blue_Sig  output  1 each  pixel colour.
REQ-014 Frame_Start_Sig  output  1  one-cycle pulse at buffer commit.

Function
REQ-015 SHALL implement 800x600@60 timing: H counter 0..1055 (visible 0..799, sync 840..967), V counter 0..627 (visible 0..599, sync 601..604).
REQ-016 H SHALL wrap 1055->0; V SHALL increment on each H wrap and wrap 627->0.
REQ-017 SHALL hold a 16x16 shadow buffer (write side) and a 16x16 active buffer (display side).
REQ-018 Write with Write_En_Sig=1 SHALL replace shadow row Write_Addr_Sig with Write_Data in that cycle; no ready/backpressure, every strobe accepted.
REQ-019 Commit SHALL occur on the cycle H=0, V=600: active <= shadow; Frame_Start_Sig high for exactly that cycle.
REQ-020 A write on the commit cycle SHALL be included in the committed image (shadow next-state bypass).
REQ-021 Writes in any other cycle SHALL NOT alter the displayed image until the next commit (no tearing).
REQ-022 Window: ORG_X <= H < ORG_X+(16<<SCALE_LOG2) and ORG_Y <= V < ORG_Y+(16<<SCALE_LOG2); col=(H-ORG_X)>>SCALE_LOG2, row=(V-ORG_Y)>>SCALE_LOG2, pixel=active[row][15-col].
REQ-023 Colour: in window -> FG_COLOR if pixel=1 else BG_COLOR; visible outside window -> BG_COLOR; blanking -> 000.
REQ-024 All outputs SHALL be registered with 1-cycle latency from the counter values; sync and colour mutually aligned.
REQ-025 Window arithmetic SHALL use 11-bit unsigned; parameters placing the window beyond 800x600 SHALL clip, never wrap.

Reset
REQ-026 RSTn low SHALL asynchronously set H=0, V=0, both buffers all-zero, all outputs 0.
REQ-027 Reset mid-frame SHALL discard the frame; after release counting restarts from (0,0), first commit at V=600.
REQ-028 First output cycle after release SHALL reflect (0,0): syncs 0, colour BG_COLOR.

Structure
REQ-029 Timing constants (H/V visible, front porch, sync, total) SHALL live in shared package vga_timing_pkg.
REQ-030 Counter/sync generation SHALL be sub-module vga_sync_gen (counters, in-visible flag, sync, commit strobe); buffers and pixel path stay in the top.
REQ-031 Buffers SHALL be flops (2x256), no RAM inference.

Verification
REQ-032 Reset release, run 1056*628 cycles -> HSYNC high 128 cycles/line; VSYNC high lines 601..604; period exactly 663168 cycles.
REQ-033 Write row 0 = 16'h8001 mid-frame, display -> unchanged this frame; after commit, lines 236..243 show FG at H 336..343 and 456..463.
REQ-034 Write row 5 = 16'hFFFF on commit cycle (H=0,V=600) -> row 5 (lines 276..283) all FG next frame; Frame_Start_Sig one pulse.
REQ-035 Two writes same row in one frame (16'h00FF then 16'hFF00) -> only 16'hFF00 displayed.
REQ-036 Assert RSTn at H=500,V=300 for 3 cycles -> outputs 0 immediately; blank image after next commit; timing restarts at (0,0).
REQ-037 All-ones bitmap -> every pixel at H=335, H=464, V=235, V=364 is BG; blanking pixels 000.
